// File: rtl/multi_glitch_filter.sv
// N-channel glitch filter: each channel commits a new level after T stable cycles and emits rise/fall strobes.
// Optional input synchroniser enabled by defining MULTI_GLITCH_FILTER_SYNC_EN (default: undefined, in used directly).
module multi_glitch_filter #(
  parameter int       CHANNELS      = 4,
  parameter int       CNT_W         = 8,
  parameter int       FILTER_CYCLES = 5,
  parameter bit       RESET_VAL     = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] in,
  input  logic [CNT_W-1:0]    cfg_cycles,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] pending
);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DEFAULT = CNT_W'(FILTER_CYCLES);

  // Threshold is shared by every channel and follows cfg_cycles live.
  logic [CNT_W-1:0] thr;
  always_comb begin
    thr = (cfg_cycles == '0) ? CNT_DEFAULT : cfg_cycles;
  end

  logic [CHANNELS-1:0] s;

`ifdef MULTI_GLITCH_FILTER_SYNC_EN
  logic [CHANNELS-1:0] sync1_q, sync1_d;
  logic [CHANNELS-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = in;
    sync2_d = sync1_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= {CHANNELS{RESET_VAL}};
      sync2_q <= {CHANNELS{RESET_VAL}};
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign s = sync2_q;
`else
  assign s = in;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W:0]   cnt_inc;
    logic             commit;

    // NOTE: every always_comb output gets a default first so no latch is inferred on untaken paths.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      commit  = 1'b0;
      cnt_inc = {1'b0, cnt_q} + {1'b0, CNT_ONE};

      case (state_q)
        ST_STABLE: begin
          if (s[i] == out_q) begin
            cnt_d = '0;
          end else if (thr == CNT_ONE) begin
            commit = 1'b1;
          end else begin
            cnt_d   = CNT_ONE;
            state_d = ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (s[i] == out_q) begin
            cnt_d   = '0;
            state_d = ST_STABLE;
          end else if (cnt_inc >= {1'b0, thr}) begin
            commit = 1'b1;
          end else begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_inc[CNT_W-1:0];
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = ST_STABLE;
        end
      endcase

      if (commit) begin
        out_d   = s[i];
        rise_d  = s[i];
        fall_d  = ~s[i];
        cnt_d   = '0;
        state_d = ST_STABLE;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= ST_STABLE;
        cnt_q   <= '0;
        out_q   <= RESET_VAL;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        out_q   <= out_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end
    end

    assign out[i]     = out_q;
    assign rise[i]    = rise_q;
    assign fall[i]    = fall_q;
    assign pending[i] = (state_q == ST_PENDING);
  end

endmodule

// File: tb/tb_multi_glitch_filter.sv
// Directed self-checking bench for multi_glitch_filter (default build: no input synchroniser).
module tb_multi_glitch_filter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in;
  logic [7:0] cfg_cycles;
  logic [3:0] out, rise, fall, pending;

  int checks = 0;
  int errors = 0;

  multi_glitch_filter #(
    .CHANNELS(4), .CNT_W(8), .FILTER_CYCLES(5), .RESET_VAL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .cfg_cycles(cfg_cycles),
    .out(out), .rise(rise), .fall(fall), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    rst_n      = 1'b0;
    in         = 4'hF;
    cfg_cycles = 8'd0;

    // Reset with all inputs high.
    ticks(2);
    check("rst_out", out, 4'h0);
    check("rst_rise", rise, 4'h0);
    check("rst_fall", fall, 4'h0);
    check("rst_pend", pending, 4'h0);
    rst_n = 1'b1;
    ticks(4);
    check("rel_pend4", pending, 4'hF);
    check("rel_out4", out, 4'h0);
    tick();
    check("rel_out5", out, 4'hF);
    check("rel_rise5", rise, 4'hF);
    tick();
    check("rel_rise6", rise, 4'h0);

    in = 4'h0;
    ticks(5);
    check("back_out", out, 4'h0);
    check("back_fall", fall, 4'hF);
    tick();

    // Clean edge on channel 0.
    in = 4'b0001;
    for (int e = 1; e <= 4; e++) begin
      tick();
      check($sformatf("clean_pend_e%0d", e), pending, 4'b0001);
      check($sformatf("clean_out_e%0d", e), out, 4'h0);
    end
    tick();
    check("clean_out5", out, 4'b0001);
    check("clean_rise5", rise, 4'b0001);
    check("clean_pend5", pending, 4'h0);
    tick();
    check("clean_rise6", rise, 4'h0);

    // Glitch on channel 1: four cycles high then low.
    in = 4'b0011;
    ticks(4);
    check("glitch_pend4", pending, 4'b0010);
    in = 4'b0001;
    tick();
    check("glitch_pend5", pending, 4'h0);
    check("glitch_out", out, 4'b0001);
    check("glitch_rise", rise, 4'h0);

    // T=1: out follows one edge later.
    cfg_cycles = 8'd1;
    in = 4'b0000;
    tick();
    check("t1_out_a", out, 4'b0000);
    check("t1_fall_a", fall, 4'b0001);
    in = 4'b0100;
    tick();
    check("t1_out_b", out, 4'b0100);
    check("t1_rise_b", rise, 4'b0100);
    in = 4'b0000;
    tick();
    check("t1_out_c", out, 4'b0000);

    // T=2 with channel 3 toggling every cycle: never commits.
    cfg_cycles = 8'd2;
    for (int k = 0; k < 6; k++) begin
      in = (k % 2 == 0) ? 4'b1000 : 4'b0000;
      tick();
      check($sformatf("toggle_out_%0d", k), out, 4'h0);
      check($sformatf("toggle_rise_%0d", k), rise, 4'h0);
    end
    in = 4'b0000;
    tick();

    // Raise T to 20 after three counted edges.
    cfg_cycles = 8'd0;
    in = 4'b0001;
    ticks(3);
    cfg_cycles = 8'd20;
    ticks(16);
    check("raise_out19", out, 4'h0);
    check("raise_pend19", pending, 4'b0001);
    tick();
    check("raise_out20", out, 4'b0001);
    check("raise_rise20", rise, 4'b0001);

    // Lower T from 20 to 2 after six counted edges.
    in = 4'b0000;
    ticks(6);
    check("lower_out6", out, 4'b0001);
    cfg_cycles = 8'd2;
    tick();
    check("lower_out7", out, 4'b0000);
    check("lower_fall7", fall, 4'b0001);

    // Independence: opposite edges on alternating channels.
    cfg_cycles = 8'd0;
    in = 4'b0101;
    ticks(5);
    check("ind_out_a", out, 4'b0101);
    tick();
    in = 4'b1010;
    ticks(4);
    check("ind_out4", out, 4'b0101);
    tick();
    check("ind_out5", out, 4'b1010);
    check("ind_rise5", rise, 4'b1010);
    check("ind_fall5", fall, 4'b0101);
    check("ind_excl", rise & fall, 4'h0);

    // Reset mid-count discards the candidate.
    in = 4'b0101;
    ticks(2);
    check("mid_pend", pending, 4'hF);
    rst_n = 1'b0;
    tick();
    check("mid_rst_out", out, 4'h0);
    check("mid_rst_pend", pending, 4'h0);
    rst_n = 1'b1;
    in = 4'b0000;
    ticks(3);
    check("mid_after_out", out, 4'h0);
    check("mid_after_pend", pending, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
